dmem_arbiter: RTL and testbench

//  Two-port arbiter/sequencer in front of the single-port data memory (byte-addressed, 0x02000000-0x02000FFF).

---
 rtl/dmem_pkg.sv | 33 +++
 rtl/dmem_rr_pick.sv | 17 +
 rtl/dmem_arbiter.sv | 146 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings and helpers for the data-memory arbiter.
//   SZ_B/SZ_H/SZ_W      access size encodings (2'b11 is illegal)
//   ST_IDLE/ACCESS/RESP sequencer state encodings
//   MEM_BASE_DEF/LAST   default data-memory window
//   access_err()        range/size check done in 33 bits so an access that
//                       runs off the top of the address space cannot wrap
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [31:0] MEM_BASE_DEF = 32'h0200_0000;
  localparam logic [31:0] MEM_LAST_DEF = 32'h0200_0FFF;

  function automatic logic access_err(input logic [31:0] addr, input logic [1:0] size,
                                      input logic [31:0] base, input logic [31:0] last);
    logic [2:0]  nbytes;
    logic [32:0] end_addr;
    case (size)
      SZ_B:    nbytes = 3'd1;
      SZ_H:    nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    end_addr = {1'b0, addr} + {30'b0, nbytes} - 33'd1;
    return (size == 2'b11) || (addr < base) || (end_addr > {1'b0, last});
  endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// dmem_rr_pick: combinational 2-way round-robin chooser.
//   req[1:0]  requests from port 1/0
//   last      port served most recently (1 = port 1)
//   gnt[1:0]  one-hot winner, 0 when nothing requests
module dmem_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    // On contention the port that was not served last wins.
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer in front of the single-port data
// memory. Port 0 = core LSU, port 1 = DMA/loader. Every access runs
// IDLE -> ACCESS -> RESP (3 cycles).
//   ip_clk, ip_rst          clock, async active-high reset
//   ip_req/we/addr/wdata/size/uns{0,1}  request command per port
//   op_gnt{0,1}             1-cycle pulse, command sampled (ACCESS cycle)
//   op_rvalid/err/rdata{0,1} completion (RESP cycle); rdata held per port
//   op_mem_*                registered memory command, store_en only in ACCESS
//   ip_mem_read_data        combinational read data from memory
// Build option: define DMEM_ALIGN_CHECK_EN to reject misaligned half/word
// accesses as errors; otherwise they pass through to memory unchanged.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter logic [31:0] MEM_BASE = MEM_BASE_DEF,
  parameter logic [31:0] MEM_LAST = MEM_LAST_DEF
) (
  input  logic        ip_clk,
  input  logic        ip_rst,
  input  logic        ip_req0,
  input  logic        ip_req1,
  input  logic        ip_we0,
  input  logic        ip_we1,
  input  logic [31:0] ip_addr0,
  input  logic [31:0] ip_addr1,
  input  logic [31:0] ip_wdata0,
  input  logic [31:0] ip_wdata1,
  input  logic [1:0]  ip_size0,
  input  logic [1:0]  ip_size1,
  input  logic        ip_uns0,
  input  logic        ip_uns1,
  output logic        op_gnt0,
  output logic        op_gnt1,
  output logic        op_rvalid0,
  output logic        op_rvalid1,
  output logic [31:0] op_rdata0,
  output logic [31:0] op_rdata1,
  output logic        op_err0,
  output logic        op_err1,
  output logic [31:0] op_mem_addr,
  output logic [31:0] op_mem_store_data,
  output logic [1:0]  op_mem_bit_ctrl,
  output logic        op_mem_sign_ctrl,
  output logic        op_mem_store_en,
  input  logic [31:0] ip_mem_read_data
);

  logic [1:0]  state;
  logic        last_srv;
  logic [1:0]  pick;
  logic        cmd_port, cmd_we, cmd_err;

  logic        sel_we, sel_uns, sel_err, sel_mis;
  logic [31:0] sel_addr, sel_wdata;
  logic [1:0]  sel_size;

  dmem_rr_pick u_pick (
    .req  ({ip_req1, ip_req0}),
    .last (last_srv),
    .gnt  (pick)
  );

  assign sel_we    = pick[1] ? ip_we1    : ip_we0;
  assign sel_addr  = pick[1] ? ip_addr1  : ip_addr0;
  assign sel_wdata = pick[1] ? ip_wdata1 : ip_wdata0;
  assign sel_size  = pick[1] ? ip_size1  : ip_size0;
  assign sel_uns   = pick[1] ? ip_uns1   : ip_uns0;

`ifdef DMEM_ALIGN_CHECK_EN
  assign sel_mis = ((sel_size == SZ_H) && sel_addr[0]) ||
                   ((sel_size == SZ_W) && (sel_addr[1:0] != 2'b00));
`else
  assign sel_mis = 1'b0;
`endif

  assign sel_err = access_err(sel_addr, sel_size, MEM_BASE, MEM_LAST) || sel_mis;

  // The memory command lines are the latched command itself, so they hold
  // their last value between accesses; store_en is its own flop so the
  // level-sensitive memory write never sees a combinational glitch.
  always_ff @(posedge ip_clk or posedge ip_rst) begin
    if (ip_rst) begin
      state             <= ST_IDLE;
      last_srv          <= 1'b1;
      cmd_port          <= 1'b0;
      cmd_we            <= 1'b0;
      cmd_err           <= 1'b0;
      op_gnt0           <= 1'b0;
      op_gnt1           <= 1'b0;
      op_rvalid0        <= 1'b0;
      op_rvalid1        <= 1'b0;
      op_err0           <= 1'b0;
      op_err1           <= 1'b0;
      op_rdata0         <= '0;
      op_rdata1         <= '0;
      op_mem_addr       <= '0;
      op_mem_store_data <= '0;
      op_mem_bit_ctrl   <= '0;
      op_mem_sign_ctrl  <= 1'b0;
      op_mem_store_en   <= 1'b0;
    end else begin
      op_gnt0         <= 1'b0;
      op_gnt1         <= 1'b0;
      op_rvalid0      <= 1'b0;
      op_rvalid1      <= 1'b0;
      op_err0         <= 1'b0;
      op_err1         <= 1'b0;
      op_mem_store_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|pick) begin
            cmd_port          <= pick[1];
            cmd_we            <= sel_we;
            cmd_err           <= sel_err;
            op_mem_addr       <= sel_addr;
            op_mem_store_data <= sel_wdata;
            op_mem_bit_ctrl   <= sel_size;
            op_mem_sign_ctrl  <= sel_uns;
            op_mem_store_en   <= sel_we & ~sel_err;
            op_gnt0           <= pick[0];
            op_gnt1           <= pick[1];
            state             <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cmd_port) begin
            op_rdata1  <= (cmd_we || cmd_err) ? 32'h0 : ip_mem_read_data;
            op_rvalid1 <= 1'b1;
            op_err1    <= cmd_err;
          end else begin
            op_rdata0  <= (cmd_we || cmd_err) ? 32'h0 : ip_mem_read_data;
            op_rvalid0 <= 1'b1;
            op_err0    <= cmd_err;
          end
          state <= ST_RESP;
        end
        ST_RESP: begin
          last_srv <= cmd_port;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed + randomized bench for dmem_arbiter with a
// byte-array memory model and a spec-level reference (shadow memory,
// round-robin rule, range/size error rule).
module tb_dmem_arbiter;

  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam logic [31:0] LAST = 32'h0200_0FFF;

  logic        ip_clk = 1'b0;
  logic        ip_rst;
  logic        r_req [2];
  logic        c_we [2];
  logic [31:0] c_addr [2];
  logic [31:0] c_wdata [2];
  logic [1:0]  c_size [2];
  logic        c_uns [2];

  logic        op_gnt0, op_gnt1, op_rvalid0, op_rvalid1, op_err0, op_err1;
  logic [31:0] op_rdata0, op_rdata1, op_mem_addr, op_mem_store_data;
  logic [1:0]  op_mem_bit_ctrl;
  logic        op_mem_sign_ctrl, op_mem_store_en;
  logic [31:0] mem_rd;

  int n_err = 0;
  int n_chk = 0;

  always #5 ip_clk = ~ip_clk;

  dmem_arbiter dut (
    .ip_clk(ip_clk), .ip_rst(ip_rst),
    .ip_req0(r_req[0]), .ip_req1(r_req[1]),
    .ip_we0(c_we[0]), .ip_we1(c_we[1]),
    .ip_addr0(c_addr[0]), .ip_addr1(c_addr[1]),
    .ip_wdata0(c_wdata[0]), .ip_wdata1(c_wdata[1]),
    .ip_size0(c_size[0]), .ip_size1(c_size[1]),
    .ip_uns0(c_uns[0]), .ip_uns1(c_uns[1]),
    .op_gnt0(op_gnt0), .op_gnt1(op_gnt1),
    .op_rvalid0(op_rvalid0), .op_rvalid1(op_rvalid1),
    .op_rdata0(op_rdata0), .op_rdata1(op_rdata1),
    .op_err0(op_err0), .op_err1(op_err1),
    .op_mem_addr(op_mem_addr), .op_mem_store_data(op_mem_store_data),
    .op_mem_bit_ctrl(op_mem_bit_ctrl), .op_mem_sign_ctrl(op_mem_sign_ctrl),
    .op_mem_store_en(op_mem_store_en), .ip_mem_read_data(mem_rd)
  );

  // ---------------- memory model (the environment) ----------------
  logic [7:0] mem [4096];
  bit         mem_init;
  int         se_cnt = 0;

  always_comb begin
    logic [11:0] a0, a1, a2, a3;
    a0 = op_mem_addr[11:0];
    a1 = a0 + 12'd1;
    a2 = a0 + 12'd2;
    a3 = a0 + 12'd3;
    case (op_mem_bit_ctrl)
      2'b00:   mem_rd = {{24{~op_mem_sign_ctrl & mem[a0][7]}}, mem[a0]};
      2'b01:   mem_rd = {{16{~op_mem_sign_ctrl & mem[a1][7]}}, mem[a1], mem[a0]};
      default: mem_rd = {mem[a3], mem[a2], mem[a1], mem[a0]};
    endcase
  end

  always @(posedge ip_clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
      mem_init <= 1'b1;
    end else if (op_mem_store_en) begin
      se_cnt <= se_cnt + 1;
      mem[op_mem_addr[11:0]] <= op_mem_store_data[7:0];
      if (op_mem_bit_ctrl != 2'b00)
        mem[op_mem_addr[11:0] + 12'd1] <= op_mem_store_data[15:8];
      if (op_mem_bit_ctrl == 2'b10) begin
        mem[op_mem_addr[11:0] + 12'd2] <= op_mem_store_data[23:16];
        mem[op_mem_addr[11:0] + 12'd3] <= op_mem_store_data[31:24];
      end
    end
  end

  // ---------------- reference model ----------------
  logic [7:0]  ref_mem [4096];
  logic [31:0] m_rdata [2];
  int          m_last;
  int          m_nst = 0;

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic m_err(input logic [31:0] a, input logic [1:0] s);
    longint unsigned top;
    logic e;
    top = longint'(a) + nbytes(s) - 1;
    e = (s == 2'd3) || (a < BASE) || (top > longint'(LAST));
`ifdef DMEM_ALIGN_CHECK_EN
    if ((s == 2'd1 && a % 2 != 0) || (s == 2'd2 && a % 4 != 0)) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] s, input logic u);
    logic [31:0] v;
    int n, idx;
    n = nbytes(s);
    idx = int'(a - BASE);
    v = 0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[idx + i]) << (8 * i));
    if (!u && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic m_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    int idx;
    idx = int'(a - BASE);
    for (int i = 0; i < nbytes(s); i++) ref_mem[idx + i] = d[8 * i +: 8];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int p, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] s, input logic u);
    c_we[p] = we; c_addr[p] = a; c_wdata[p] = d; c_size[p] = s; c_uns[p] = u;
    r_req[p] = 1'b1;
  endtask

  // Called at a negedge whose following posedge finds the arbiter in IDLE
  // with at least one request up; walks one full 3-cycle access.
  task automatic serve();
    int w, o;
    logic e, st;
    logic [31:0] exp_rd;
    if (r_req[0] && r_req[1]) w = (m_last == 1) ? 0 : 1;
    else w = r_req[1] ? 1 : 0;
    o = 1 - w;
    e = m_err(c_addr[w], c_size[w]);
    st = c_we[w] && !e;
    exp_rd = (c_we[w] || e) ? 32'h0 : m_load(c_addr[w], c_size[w], c_uns[w]);
    @(negedge ip_clk);
    chk("gnt0", {31'b0, op_gnt0}, {31'b0, w == 0});
    chk("gnt1", {31'b0, op_gnt1}, {31'b0, w == 1});
    chk("store_en_access", {31'b0, op_mem_store_en}, {31'b0, st});
    chk("mem_addr", op_mem_addr, c_addr[w]);
    r_req[w] = 1'b0;
    if (st) begin
      m_store(c_addr[w], c_size[w], c_wdata[w]);
      m_nst++;
    end
    @(negedge ip_clk);
    chk("rvalid_win", {31'b0, (w == 0) ? op_rvalid0 : op_rvalid1}, 32'd1);
    chk("rvalid_other", {31'b0, (o == 0) ? op_rvalid0 : op_rvalid1}, 32'd0);
    chk("err", {31'b0, (w == 0) ? op_err0 : op_err1}, {31'b0, e});
    chk("rdata", (w == 0) ? op_rdata0 : op_rdata1, exp_rd);
    chk("store_en_resp", {31'b0, op_mem_store_en}, 32'd0);
    m_rdata[w] = exp_rd;
    m_last = w;
    chk("rdata_hold", (o == 0) ? op_rdata0 : op_rdata1, m_rdata[o]);
    @(negedge ip_clk);
    chk("rvalid_idle", {30'b0, op_rvalid1, op_rvalid0}, 32'd0);
  endtask

  function automatic logic [31:0] rnd_addr();
    case ($urandom_range(0, 3))
      0:       return BASE + $urandom_range(0, 32'hFFF);
      1:       return LAST - $urandom_range(0, 4);
      2:       return BASE - $urandom_range(1, 8);
      default: return (BASE + $urandom_range(0, 32'hFF)) & ~32'h3;
    endcase
  endfunction

  function automatic logic [1:0] rnd_size();
    return ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
  endfunction

  initial begin
    int bad;
    ip_rst = 1'b1;
    for (int p = 0; p < 2; p++) begin
      r_req[p] = 0; c_we[p] = 0; c_addr[p] = 0; c_wdata[p] = 0; c_size[p] = 0; c_uns[p] = 0;
      m_rdata[p] = 0;
    end
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    m_last = 1;
    repeat (3) @(negedge ip_clk);
    chk("rst_gnt", {30'b0, op_gnt1, op_gnt0}, 32'd0);
    chk("rst_rvalid", {30'b0, op_rvalid1, op_rvalid0}, 32'd0);
    chk("rst_rdata0", op_rdata0, 32'd0);
    chk("rst_mem_addr", op_mem_addr, 32'd0);
    chk("rst_store_en", {31'b0, op_mem_store_en}, 32'd0);
    ip_rst = 1'b0;
    @(negedge ip_clk);

    // SW then LW at the same word
    issue(0, 1, 32'h0200_0010, 32'hDEAD_BEEF, 2'd2, 0); serve();
    issue(0, 0, 32'h0200_0010, 32'h0, 2'd2, 0); serve();
    chk("t1_lw", op_rdata0, 32'hDEAD_BEEF);

    // contention, twice
    for (int k = 0; k < 2; k++) begin
      issue(0, 0, 32'h0200_0010, 0, 2'd2, 0);
      issue(1, 0, 32'h0200_0012, 0, 2'd1, 1);
      serve(); serve();
    end

    // signed / unsigned byte load
    issue(0, 1, 32'h0200_0010, 32'h0000_0080, 2'd0, 0); serve();
    issue(1, 0, 32'h0200_0010, 0, 2'd0, 0); serve();
    chk("t3_lb", op_rdata1, 32'hFFFF_FF80);
    issue(1, 0, 32'h0200_0010, 0, 2'd0, 1); serve();
    chk("t3_lbu", op_rdata1, 32'h0000_0080);

    // out-of-range accesses
    issue(0, 1, 32'h0200_0FFE, 32'h1234_5678, 2'd2, 0); serve();
    issue(1, 0, 32'h01FF_FFFC, 0, 2'd2, 0); serve();
    chk("t4_err_rdata", op_rdata1, 32'd0);

    // reset during ACCESS of a store
    issue(0, 1, 32'h0200_0020, 32'hCAFE_F00D, 2'd2, 0);
    @(negedge ip_clk);
    chk("t5_store_en_pre", {31'b0, op_mem_store_en}, 32'd1);
    r_req[0] = 1'b0;
    ip_rst = 1'b1;
    #1;
    chk("t5_store_en_async", {31'b0, op_mem_store_en}, 32'd0);
    #1 ip_rst = 1'b0;
    m_last = 1;
    m_rdata[0] = 0; m_rdata[1] = 0;
    @(negedge ip_clk);
    chk("t5_no_rvalid", {30'b0, op_rvalid1, op_rvalid0}, 32'd0);
    issue(0, 0, 32'h0200_0020, 0, 2'd2, 0); serve();

    // misaligned halfword
    issue(0, 1, 32'h0200_0011, 32'h0000_A5C3, 2'd1, 0); serve();
    issue(1, 0, 32'h0200_0011, 0, 2'd1, 1); serve();
`ifdef DMEM_ALIGN_CHECK_EN
    chk("t6_lh", op_rdata1, 32'h0);
`else
    chk("t6_lh", op_rdata1, 32'h0000_A5C3);
`endif

    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      int mode;
      mode = $urandom_range(0, 2);
      for (int p = 0; p < 2; p++)
        if (mode == 2 || mode == p)
          issue(p, 1'($urandom_range(0, 1)), rnd_addr(), $urandom, rnd_size(), 1'($urandom_range(0, 1)));
      serve();
      if (mode == 2) serve();
    end

    bad = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_final", bad, 0);
    chk("store_count", se_cnt, m_nst);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
